// File: rtl/msfsm_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : msfsm_sched_pkg                                           |
// | Purpose  : Shared constants for the MSFSM transition scheduler:      |
// |            default sizes, controller state encoding and the          |
// |            transition-index width derivation.                        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package msfsm_sched_pkg;

  localparam int N_FSM_DEF   = 3;
  localparam int N_TRANS_DEF = 9;
  localparam int TIMEOUT_DEF = 15;

  // Controller states, kept as plain sized constants for older tool flows.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Index width for a transition number; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : msfsm_sched_pkg
`default_nettype wire

// File: rtl/msfsm_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : msfsm_rr_pick                                             |
// | Purpose  : Combinational round-robin find-first. Returns the first   |
// |            set request at or above ptr, wrapping past N_TRANS-1.     |
// | Ports    : req   [N_TRANS] request vector                            |
// |            ptr   [IW]      search start index (< N_TRANS)            |
// |            valid           any request set                           |
// |            idx   [IW]      winning index                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module msfsm_rr_pick
  import msfsm_sched_pkg::*;
#(
  parameter int N_TRANS = N_TRANS_DEF,
  parameter int IW      = idx_width(N_TRANS)
) (
  input  logic [N_TRANS-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  // Scan offsets from the far end downward so the smallest offset from
  // ptr is the last assignment and therefore wins.
  always_comb begin : p_pick
    int cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = N_TRANS - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N_TRANS) cand = cand - N_TRANS;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule : msfsm_rr_pick
`default_nettype wire

// File: rtl/msfsm_sync_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : msfsm_sync_scheduler                                      |
// | Purpose  : Central transition scheduler for a multiple-synchronised  |
// |            FSM dual-rail gate. Fires a shared transition when every  |
// |            participating FSM is ready, arbitrates round-robin and    |
// |            runs a fire/ack handshake with timeout.                   |
// | Ports    : clk, reset (async, active-low)                            |
// |            cfg_en, cfg_d   serial participation-mask load            |
// |            ready [N_FSM*N_TRANS]  per-FSM per-transition readiness   |
// |            ack   [N_FSM]   per-FSM acknowledge pulse                 |
// |            fire  [N_TRANS] one-hot fire pulse                        |
// |            grant_idx       last fired transition                     |
// |            busy, done, error  handshake status                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module msfsm_sync_scheduler
  import msfsm_sched_pkg::*;
#(
  parameter int N_FSM   = N_FSM_DEF,
  parameter int N_TRANS = N_TRANS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int IW      = idx_width(N_TRANS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_en,
  input  logic                     cfg_d,
  input  logic [N_FSM*N_TRANS-1:0] ready,
  input  logic [N_FSM-1:0]         ack,
  output logic [N_TRANS-1:0]       fire,
  output logic [IW-1:0]            grant_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int MW = N_FSM * N_TRANS;

  state_t             state,  state_nx;
  logic [MW-1:0]      mask,   mask_nx;
  logic [IW-1:0]      ptr,    ptr_nx;
  logic [IW-1:0]      grant_nx;
  logic [N_FSM-1:0]   coll,   coll_nx;
  logic [7:0]         tcnt,   tcnt_nx;
  logic [N_TRANS-1:0] fire_nx;
  logic               done_nx;
  logic               error_nx;

  logic [N_TRANS-1:0] enabled;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [N_FSM-1:0]   mask_g;
  logic [IW-1:0]      ptr_inc;

  // A transition is enabled only when it has at least one participant and
  // every participant reports ready for it.
  for (genvar j = 0; j < N_TRANS; j++) begin : g_en
    logic [N_FSM-1:0] mj;
    logic [N_FSM-1:0] rj;
    assign mj         = mask[j*N_FSM +: N_FSM];
    assign rj         = ready[j*N_FSM +: N_FSM];
    assign enabled[j] = (|mj) && ((rj & mj) == mj);
  end

  msfsm_rr_pick #(
    .N_TRANS (N_TRANS),
    .IW      (IW)
  ) u_pick (
    .req   (enabled),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Participation slice of the granted transition.
  always_comb begin
    mask_g = '0;
    for (int j = 0; j < N_TRANS; j++) begin
      if (grant_idx == IW'(j)) mask_g = mask[j*N_FSM +: N_FSM];
    end
  end

  assign ptr_inc = (grant_idx == IW'(N_TRANS - 1)) ? '0 : grant_idx + IW'(1);

  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    ptr_nx   = ptr;
    grant_nx = grant_idx;
    coll_nx  = coll;
    tcnt_nx  = tcnt;
    fire_nx  = '0;
    done_nx  = 1'b0;
    error_nx = error;
    case (state)
      ST_IDLE: begin
        if (cfg_en) begin
          mask_nx = {cfg_d, mask[MW-1:1]};
        end else if (pick_valid) begin
          state_nx = ST_FIRE;
          grant_nx = pick_idx;
          tcnt_nx  = '0;
          for (int j = 0; j < N_TRANS; j++) begin
            fire_nx[j] = (pick_idx == IW'(j));
          end
        end
      end
      ST_FIRE, ST_WAIT: begin
        // The collector restarts on the fire cycle so stale acks from a
        // previous handshake can never count toward this one.
        coll_nx = ((state == ST_FIRE) ? '0 : coll) | (ack & mask_g);
        if (|(ack & ~mask_g)) error_nx = 1'b1;
        // Full acknowledge wins over a timeout in the same cycle.
        if (coll_nx == mask_g) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          ptr_nx   = ptr_inc;
        end else if (tcnt == 8'(TIMEOUT - 1)) begin
          state_nx = ST_IDLE;
          error_nx = 1'b1;
          ptr_nx   = ptr_inc;
        end else begin
          state_nx = ST_WAIT;
          tcnt_nx  = tcnt + 8'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      mask      <= '0;
      ptr       <= '0;
      grant_idx <= '0;
      coll      <= '0;
      tcnt      <= '0;
      fire      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nx;
      mask      <= mask_nx;
      ptr       <= ptr_nx;
      grant_idx <= grant_nx;
      coll      <= coll_nx;
      tcnt      <= tcnt_nx;
      fire      <= fire_nx;
      busy      <= (state_nx != ST_IDLE);
      done      <= done_nx;
      error     <= error_nx;
    end
  end

endmodule : msfsm_sync_scheduler
`default_nettype wire

// File: tb/tb_msfsm_sync_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_msfsm_sync_scheduler                                   |
// | Purpose  : Directed self-checking bench for msfsm_sync_scheduler.    |
// |            Expected fire indices are queued as stimulus is applied   |
// |            and popped whenever the scheduler fires.                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_msfsm_sync_scheduler;

  localparam int NF = 3;
  localparam int NT = 9;
  localparam int MW = NF * NT;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_en;
  logic          cfg_d;
  logic [MW-1:0] ready;
  logic [NF-1:0] ack;
  logic [NT-1:0] fire;
  logic [3:0]    grant_idx;
  logic          busy;
  logic          done;
  logic          error;

  msfsm_sync_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_en    (cfg_en),
    .cfg_d     (cfg_d),
    .ready     (ready),
    .ack       (ack),
    .fire      (fire),
    .grant_idx (grant_idx),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int prev_fire = -1;
  bit rr_mode = 1'b0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then sample outputs 1 time unit after the edge.
  // Any fire is matched against the scoreboard.
  task automatic tick();
    int e;
    logic [NT-1:0] oh;
    @(posedge clk);
    #1;
    cyc++;
    if (done === 1'b1) done_cnt++;
    if (fire !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fire", 32'(fire), 32'd0);
      end else begin
        e  = exp_q.pop_front();
        oh = NT'(1) << e;
        check("fire_vec", 32'(fire), 32'(oh));
        check("grant_idx", 32'(grant_idx), 32'(e));
        if (rr_mode && prev_fire >= 0) check("rr_spacing", 32'(cyc - prev_fire), 32'd2);
        prev_fire = cyc;
      end
    end
  endtask

  // First bit shifted in ends at bit 0, so shift LSB first.
  task automatic load_mask(input logic [MW-1:0] m);
    for (int i = 0; i < MW; i++) begin
      cfg_en = 1'b1;
      cfg_d  = m[i];
      tick();
    end
    cfg_en = 1'b0;
    cfg_d  = 1'b0;
  endtask

  initial begin
    logic [MW-1:0] m;
    int d0;
    reset  = 1'b0;
    cfg_en = 1'b0;
    cfg_d  = 1'b0;
    ready  = '0;
    ack    = '0;

    // Reset state
    tick(); tick();
    check("rst_fire", 32'(fire), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    tick();

    // Empty mask: nothing fires even with everything ready.
    ready = '1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_no_busy", 32'(busy), 32'd0);
    ready = '0;

    // Config load: t0=111, t5=010; all ready except t0 -> only t5.
    m = '0;
    m[2:0]   = 3'b111;
    m[17:15] = 3'b010;
    load_mask(m);
    ready = '1;
    ready[2:0] = 3'b000;
    exp_q.push_back(5);
    tick();
    check("cfg_busy", 32'(busy), 32'd1);
    ready = '0;
    ack   = 3'b010;
    tick();
    ack = '0;
    check("cfg_done", 32'(done), 32'd1);
    check("cfg_busy_low", 32'(busy), 32'd0);

    // Basic handshake on t0 with staggered acks.
    ready[2:0] = 3'b111;
    exp_q.push_back(0);
    tick();
    ready = '0;
    ack   = 3'b001;
    tick();
    check("hs_fire_pulse", 32'(fire), 32'd0);
    check("hs_busy_wait", 32'(busy), 32'd1);
    check("hs_no_done_early", 32'(done), 32'd0);
    ack = 3'b010;
    tick();
    ack = 3'b100;
    tick();
    ack = '0;
    check("hs_done", 32'(done), 32'd1);
    check("hs_busy_low", 32'(busy), 32'd0);
    check("hs_error", 32'(error), 32'd0);
    tick();
    check("hs_done_pulse", 32'(done), 32'd0);

    // Round-robin between t2 and t7 with immediate acks.
    m = '0;
    m[6]  = 1'b1;
    m[21] = 1'b1;
    load_mask(m);
    ready = '1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(2);
      exp_q.push_back(7);
    end
    rr_mode   = 1'b1;
    prev_fire = -1;
    for (int i = 0; i < 11; i++) begin
      tick();
      ack = (fire !== '0) ? 3'b001 : 3'b000;
    end
    ready = '0;
    tick();
    ack = '0;
    rr_mode = 1'b0;
    check("rr_all_fired", 32'(exp_q.size()), 32'd0);
    check("rr_last_done", 32'(done), 32'd1);

    // Timeout: t3 mask 011, only FSM0 acks.
    m = '0;
    m[10:9] = 2'b11;
    load_mask(m);
    ready[10:9] = 2'b11;
    exp_q.push_back(3);
    d0 = done_cnt;
    tick();
    ready = '0;
    ack   = 3'b001;
    tick();
    ack = '0;
    for (int i = 0; i < 13; i++) tick();
    check("to_error_before", 32'(error), 32'd0);
    check("to_busy_before", 32'(busy), 32'd1);
    tick();
    check("to_error", 32'(error), 32'd1);
    check("to_busy_low", 32'(busy), 32'd0);
    check("to_no_done", 32'(done_cnt - d0), 32'd0);

    // Pointer after timeout is 4: with t3 and t4 both enabled, t4 wins.
    m = '0;
    m[9]  = 1'b1;
    m[12] = 1'b1;
    load_mask(m);
    ready = '1;
    exp_q.push_back(4);
    tick();
    ready = '0;
    ack   = 3'b001;
    tick();
    ack = '0;
    check("ptr_done", 32'(done), 32'd1);
    check("error_sticky", 32'(error), 32'd1);

    // Reset mid-WAIT on t1.
    m = '0;
    m[3] = 1'b1;
    load_mask(m);
    ready[3] = 1'b1;
    exp_q.push_back(1);
    tick();
    ready = '0;
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    check("arst_grant", 32'(grant_idx), 32'd0);
    check("arst_fire", 32'(fire), 32'd0);
    d0 = done_cnt;
    tick();
    reset = 1'b1;
    ack   = 3'b001;
    ready = '1;
    for (int i = 0; i < 6; i++) tick();
    ack = '0;
    check("arst_no_done", 32'(done_cnt - d0), 32'd0);
    check("arst_mask_clear", 32'(busy), 32'd0);
    ready = '0;

    // Stray ack from FSM2 while waiting on t1 (mask 001).
    load_mask(m);
    ready[3] = 1'b1;
    exp_q.push_back(1);
    tick();
    ready = '0;
    tick();
    ack = 3'b100;
    tick();
    ack = '0;
    check("stray_error", 32'(error), 32'd1);
    check("stray_busy", 32'(busy), 32'd1);
    check("stray_no_done", 32'(done), 32'd0);
    ack = 3'b001;
    tick();
    ack = '0;
    check("stray_done", 32'(done), 32'd1);
    check("stray_error_kept", 32'(error), 32'd1);

    // Ack in IDLE is ignored; nothing left in the scoreboard.
    tick();
    ack = 3'b111;
    tick();
    ack = '0;
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_msfsm_sync_scheduler
`default_nettype wire

// File: doc/msfsm_sync_scheduler.md
# msfsm_sync_scheduler

Central transition scheduler for a multiple-synchronised-FSM (MSFSM) implementation of a dual-rail gate. Each FSM reports per-transition readiness; the scheduler fires a shared transition only when every participating FSM is ready, picks round-robin among competing enabled transitions, and completes a fire/ack handshake with the participants. Participation masks are loaded serially over the same EN/D style configuration path used by the FSM instances.

## Interface

- N_FSM, 3, number of synchronised FSMs
- N_TRANS, 9, number of shared transitions (t0..t8)
- TIMEOUT, 15, max cycles from fire to full acknowledge, 2..255
- IW, $clog2(N_TRANS), transition index width

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- cfg_en  in  1  serial configuration shift enable
- cfg_d  in  1  serial configuration data
- ready  in  N_FSM*N_TRANS  bit j*N_FSM+k: FSM k is in a state enabling transition j
- ack  in  N_FSM  one-cycle pulse: FSM k has taken the fired transition
- fire  out  N_TRANS  one-hot, one-cycle pulse: transition j fires
- grant_idx  out  IW  index of the most recently fired transition
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse: handshake completed by full ack
- error  out  1  sticky: timeout or ack from a non-participant

## Operation

- Mask register M, N_FSM*N_TRANS bits; M[j*N_FSM+k]=1 means FSM k participates in transition j. Reset value all zeros, so nothing fires until configured.
- Config: in IDLE with cfg_en=1, M shifts right one bit per cycle and cfg_d enters the MSB. After N_FSM*N_TRANS cycles the first bit shifted in sits at bit 0. cfg_en outside IDLE is ignored and M is unchanged. While cfg_en=1 no arbitration occurs.
- Enabled(j) = M_j nonzero AND (ready_j & M_j) == M_j, where M_j is the N_FSM-bit slice for transition j.
- States: IDLE, FIRE, WAIT.
  - IDLE -> FIRE when cfg_en=0 and any transition is enabled. Winner is the first enabled index searching upward from pointer ptr, wrapping at N_TRANS-1 -> 0. The winner is registered into grant_idx.
  - FIRE: lasts one cycle with fire[grant_idx]=1. The ack collector is initialised to ack & M_g. Next state is WAIT. If the collector already equals M_g, go straight to IDLE with done=1 on the next cycle.
  - WAIT: collector |= ack & M_g. When the collector equals M_g, go to IDLE and pulse done for one cycle.
- Any ack bit outside M_g during FIRE/WAIT sets error. The handshake continues.
- Timeout counter starts at 0 in FIRE and increments each FIRE/WAIT cycle. On reaching TIMEOUT without full ack: set error, return to IDLE, no done pulse.
- On leaving WAIT or FIRE by either path, ptr = (grant_idx+1) mod N_TRANS.
- ack in IDLE is ignored without error. ready may change freely and is sampled only in IDLE.
- Reset values: fire=0, grant_idx=0, busy=0, done=0, error=0, ptr=0, M=0, state IDLE. Reset asserted mid-handshake aborts immediately with no done pulse.

## Timing

- Enabled transition seen in IDLE at cycle c: fire high in cycle c+1, busy high from c+1.
- Acks completing in cycle c (FIRE or WAIT): done high and busy low in cycle c+1. The earliest next fire is c+2.
- Minimum period between consecutive fires: 2 cycles (ack arriving in the FIRE cycle).
- All outputs are registered; no combinational path from inputs to outputs.
- error clears only on reset.

## Structure

- Package msfsm_sched_pkg holds the state enum (IDLE, FIRE, WAIT), default N_FSM/N_TRANS/TIMEOUT constants, and the IW derivation.
- Sub-module msfsm_rr_pick is a combinational round-robin find-first. Inputs: N_TRANS request vector and ptr. Outputs: valid and index.
- Everything else (mask shift register, ack collector, timeout counter, FSM) lives in the top.

## Test plan

- Config load: shift 27 bits making t0 mask 3'b111 and t5 mask 3'b010. Read back by behaviour: with all ready bits 1 except t0's, only t5 fires, and grant_idx=5.
- Basic handshake: t0 mask 111, t0 ready in all FSMs at cycle 10. Expect fire[0] at 11. Acks at 11, 12, 13 from FSMs 0, 1, 2. Expect done at 14, busy low at 14, error=0.
- Round-robin: t2 and t7 both permanently enabled with immediate acks. Expect fires alternating 2, 7, 2, 7, each 2 cycles apart.
- Timeout: t3 mask 011 with only FSM 0 acking. Expect error=1 at cycle fire+15, no done pulse, IDLE, ptr=4.
- Stray ack: t1 mask 001 with ack from FSM 2 during WAIT. Expect error=1 while the handshake still completes with done.
- Reset mid-WAIT: assert reset after the fire. Outputs are zero immediately, M=0, and nothing fires after release until reconfigured.
